// File: rtl/beep_player.sv
// Song player for a passive buzzer: walks SONG_LEN note slots from an external
// note memory and produces a registered square wave per note with a silent tail.
module beep_player #(
    parameter int NOTE_TIME  = 15_000_000,
    parameter int GAP_TIME   = 500_000,
    parameter int SONG_LEN   = 48,
    parameter int AW         = 6,
    parameter int TONE_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [1:0]    duty_sel,
    output logic [AW-1:0] note_addr,
    input  logic [4:0]    note_data,
    output logic          pwm,
    output logic          busy,
    output logic          done,
    output logic [2:0]    cur_note
);

    localparam int PLAY_LAST = NOTE_TIME - GAP_TIME - 2;
    localparam int GAP_LAST  = (GAP_TIME > 0) ? GAP_TIME - 1 : 0;
    localparam int TW        = $clog2(NOTE_TIME + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pwm_q, pwm_d;
    logic [4:0]    note_q, note_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [17:0]   pcnt_q, pcnt_d;

    logic [17:0]   period;
    logic [17:0]   thresh;
    logic          audible;
    logic          slot_end;

    function automatic logic [17:0] base_period(input logic [2:0] n);
        case (n)
            3'd1:    return 18'd190839;
            3'd2:    return 18'd170067;
            3'd3:    return 18'd151514;
            3'd4:    return 18'd143265;
            3'd5:    return 18'd127550;
            3'd6:    return 18'd113635;
            3'd7:    return 18'd101213;
            default: return 18'd0;
        endcase
    endfunction

    // Octave comes from the latched slot; duty is deliberately taken live.
    always_comb begin
        period  = base_period(note_q[2:0]) >> (int'(note_q[4:3]) + TONE_SHIFT);
        thresh  = period >> (int'(duty_sel) + 1);
        audible = (note_q[2:0] != 3'd0) && (period >= 18'd2);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pwm_d    = 1'b0;
        note_d   = note_q;
        tmr_d    = tmr_q;
        pcnt_d   = pcnt_q;
        slot_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    tmr_d   = '0;
                    pcnt_d  = '0;
                end
            end
            LOAD: begin
                note_d  = note_data;
                pcnt_d  = '0;
                tmr_d   = '0;
                state_d = PLAY;
            end
            PLAY: begin
                pcnt_d = (audible && (pcnt_q < period - 18'd1)) ? pcnt_q + 18'd1 : 18'd0;
                if (tmr_q == TW'(PLAY_LAST)) begin
                    // pwm_d stays 0 here so the following GAP/LOAD cycle is silent.
                    tmr_d = '0;
                    if (GAP_TIME > 0) begin
                        state_d = GAP;
                    end else begin
                        slot_end = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                    pwm_d = audible && (pcnt_q < thresh);
                end
            end
            GAP: begin
                if (tmr_q == TW'(GAP_LAST)) begin
                    slot_end = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (slot_end) begin
            tmr_d = '0;
            if (addr_q == AW'(SONG_LEN - 1)) begin
                addr_d = '0;
                if (loop_en) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = LOAD;
            end
        end

        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            addr_d  = '0;
            pwm_d   = 1'b0;
            done_d  = 1'b0;
            tmr_d   = '0;
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pwm_q   <= 1'b0;
            note_q  <= '0;
            tmr_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pwm_q   <= pwm_d;
            note_q  <= note_d;
            tmr_q   <= tmr_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign note_addr = addr_q;
    assign pwm       = pwm_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_note  = note_q[2:0];

endmodule

// File: tb/tb_beep_player.sv
// Directed bench for beep_player: per-cycle pwm scoreboard plus slot/control checks.
module tb_beep_player;

    localparam int NT   = 400;
    localparam int GT   = 40;
    localparam int SL   = 3;
    localparam int TS   = 12;
    localparam int AWID = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            loop_en = 1'b0;
    logic [1:0]      duty_sel = 2'd0;
    logic [AWID-1:0] note_addr;
    logic [4:0]      note_data;
    logic            pwm;
    logic            busy;
    logic            done;
    logic [2:0]      cur_note;

    logic [4:0] mem [SL];
    bit         sb [$];
    int         n_checks = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign note_data = (int'(note_addr) < SL) ? mem[int'(note_addr)] : 5'd0;

    beep_player #(
        .NOTE_TIME (NT),
        .GAP_TIME  (GT),
        .SONG_LEN  (SL),
        .AW        (AWID),
        .TONE_SHIFT(TS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .duty_sel (duty_sel),
        .note_addr(note_addr),
        .note_data(note_data),
        .pwm      (pwm),
        .busy     (busy),
        .done     (done),
        .cur_note (cur_note)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int base_of(input int n);
        case (n)
            1: return 190839;
            2: return 170067;
            3: return 151514;
            4: return 143265;
            5: return 127550;
            6: return 113635;
            7: return 101213;
            default: return 0;
        endcase
    endfunction

    // Expected pwm in slot cycle cn (0 = LOAD); value is decided one cycle earlier.
    function automatic bit exp_pwm(input int cn, input logic [4:0] nd, input int duty);
        int per, thr, k;
        if (cn < 2 || cn > NT - GT - 1) return 1'b0;
        if (nd[2:0] == 3'd0) return 1'b0;
        per = base_of(int'(nd[2:0])) >> (int'(nd[4:3]) + TS);
        if (per < 2) return 1'b0;
        thr = per >> (duty + 1);
        k = cn - 1;
        return ((k - 1) % per) < thr;
    endfunction

    task automatic pop_check_pwm(input string tag);
        bit e;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(tag, 32'(pwm), 32'(e));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        sb.push_back(1'b0);
        tick();
        start = 1'b0;
    endtask

    // Runs ncyc cycles from a LOAD cycle, checking every cycle against the model.
    task automatic run_song(input int ncyc);
        int s, c, d;
        for (int g = 0; g < ncyc; g++) begin
            s = (g / NT) % SL;
            c = g % NT;
            d = (s == 1) ? ((c < 200) ? 2 : 0) : 0;
            duty_sel = 2'(d);
            pop_check_pwm("pwm");
            check("note_addr", 32'(note_addr), 32'(s));
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'd0);
            if (c == 1) check("cur_note", 32'(cur_note), 32'(mem[s][2:0]));
            sb.push_back(exp_pwm((c + 1) % NT, mem[s], d));
            tick();
        end
    endtask

    initial begin
        mem[0] = 5'b00_001;
        mem[1] = 5'b01_110;
        mem[2] = 5'b00_000;

        tick();
        tick();
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(note_addr), 32'd0);
        check("rst_note", 32'(cur_note), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Full non-looping song: DO, LA with mid-note duty change, rest.
        do_start();
        run_song(NT * SL);
        pop_check_pwm("end_pwm");
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_addr", 32'(note_addr), 32'd0);
        tick();
        check("done_once", 32'(done), 32'd0);
        check("idle_busy2", 32'(busy), 32'd0);
        sb.delete();
        tick();

        // Looping song that wraps back into slot 0, then stop+start mid-PLAY.
        loop_en = 1'b1;
        do_start();
        run_song(NT * SL + 300);
        pop_check_pwm("pre_stop_pwm");
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        loop_en = 1'b0;
        sb.delete();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_pwm", 32'(pwm), 32'd0);
        check("stop_addr", 32'(note_addr), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stop_idle_busy", 32'(busy), 32'd0);
            check("stop_idle_done", 32'(done), 32'd0);
            check("stop_idle_pwm", 32'(pwm), 32'd0);
        end

        // Restart, then asynchronous reset while pwm is high.
        do_start();
        run_song(5);
        pop_check_pwm("pre_rst_pwm");
        check("pre_rst_high", 32'(pwm), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_addr", 32'(note_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/beep_player.md
Name: beep_player

Overview:
- Parametrised successor to the single-tune buzzer driver.
- Plays a song of SONG_LEN note slots, read from an external note memory through an address/data port.
- Supports 4 octaves, selectable PWM duty, rests, an articulation gap per note, start/stop control and loop mode.
- Drives the passive buzzer pin directly; sits between the song ROM and the board pwm pad.

Parameters:
- NOTE_TIME, 15_000_000, clock cycles per note slot (300 ms at 50 MHz); must be > GAP_TIME+1.
- GAP_TIME, 500_000, silent cycles at the end of each slot; 0 disables the gap.
- SONG_LEN, 48, number of note slots in the song (1..2^AW).
- AW, 6, width of note_addr.
- TONE_SHIFT, 0, extra right shift applied to every tone period (simulation speed-up).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin playback from slot 0 when idle
- stop  in  1  abort playback
- loop_en  in  1  restart at slot 0 after the last slot instead of finishing
- duty_sel  in  2  duty: 0=1/2, 1=1/4, 2=1/8, 3=1/16
- note_addr  out  AW  current slot address to the note memory
- note_data  in  5  {octave[1:0], note[2:0]}; note 0=rest, 1..7=DO..SI; combinational read of note_addr
- pwm  out  1  buzzer drive, registered
- busy  out  1  high while playing
- done  out  1  one-cycle pulse when a non-looping song finishes
- cur_note  out  3  note field of the latched slot

Behaviour:
- Reset: pwm=0, busy=0, done=0, note_addr=0, cur_note=0, state IDLE, all counters 0.
- Base periods in cycles, 18-bit: DO 190839, RE 170067, MI 151514, FA 143265, SO 127550, LA 113635, SI 101213.
- Tone period: base >> (octave+TONE_SHIFT).
- High threshold: period >> (duty_sel+1).
- Period < 2 is treated as a rest.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE -> LOAD when start=1 and stop=0. Set busy=1, note_addr=0, slot counter=0.
- LOAD (1 cycle): latch note_reg <= note_data; clear the period counter. Always go to PLAY.
- PLAY lasts NOTE_TIME-GAP_TIME-1 cycles.
  - Period counter runs 0..period-1 and wraps.
  - pwm <= (note!=0) && (pcnt < threshold), so pwm first goes high in the 2nd PLAY cycle.
  - duty_sel is sampled live.
- GAP lasts GAP_TIME cycles with pwm forced 0. The state is skipped when GAP_TIME=0.
- Total slot length is exactly NOTE_TIME cycles, counting from LOAD.
- End of slot, not the last slot: note_addr+1, go to LOAD.
- End of slot, last slot (note_addr==SONG_LEN-1):
  - loop_en=1 (sampled this cycle): note_addr=0, go to LOAD, no done.
  - loop_en=0: done=1 for one cycle, busy=0, note_addr=0, go to IDLE.
- pwm=0 in IDLE, LOAD, GAP and during rests.
- stop=1 in any state: go to IDLE on the next edge with pwm=0, busy=0, note_addr=0, and no done pulse.
- stop has priority over start when both are asserted in the same cycle.
- start while busy is ignored.
- Asynchronous reset mid-song returns everything to reset values immediately.

Test Plan:
Common setup: NOTE_TIME=400, GAP_TIME=40, SONG_LEN=3, TONE_SHIFT=12.
- Reset check: assert rst_n=0 mid-run -> pwm, busy, done and note_addr all 0 immediately.
- DO, octave 0, duty_sel 0: start pulse, note_data=5'b00_001 -> period 46, pwm 23 high / 23 low, 0 during the last 40 cycles of the slot, note_addr 0->1 exactly 400 cycles after LOAD.
- LA, octave 1, duty_sel 2: note_data=5'b01_110 -> period 13, 1 high / 12 low. Then duty_sel 0 mid-note -> 6 high / 7 low.
- Rest: note_data=0 -> pwm stays 0 for the whole 400-cycle slot; cur_note=0.
- Song end, loop_en=0: done pulses once, 1200 cycles after the first LOAD; busy falls in the same cycle; note_addr=0.
- Song end, loop_en=1: note_addr wraps 2->0 with no done pulse and busy held high.
- Stop: assert stop and start together mid-PLAY -> IDLE on the next edge, pwm 0, busy 0, no done; start alone then restarts at slot 0.
